// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Instruction memory with a streaming program loader and a one-cycle fetch port.
//   The 2^ADDR_W x WORD_W memory is split into an even-address bank and an
//   odd-address bank. A fetch needs the word pair {mem[a], mem[a+1]}, which
//   always spans one even and one odd address. Each bank therefore needs one
//   write port and one registered read port, which maps onto a simple dual-port
//   block RAM.
//
// Optional build macro: IMEM_PARITY_EN
//   Stores one even-parity bit per word and adds the par_err output.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   pc            fetch address (only pc[ADDR_W-1:0] is used)
//   fetch_req     fetch request; serviced only while IDLE
//   instr         {mem[pc], mem[pc+1]}, one cycle after an accepted fetch
//   instr_valid   one-cycle qualifier for instr
//   ld_start      start a load (base/len latched); ignored while loading
//   ld_base       first load address
//   ld_len        number of words to load
//   ld_valid      ld_data is valid
//   ld_data       load word
//   ld_ready      high while loading (in LOAD state)
//   ld_done       one-cycle completion pulse
//   busy          high while loading
//   par_err       (IMEM_PARITY_EN only) parity failure on either fetched word
module instr_mem_loader #(
   parameter int ADDR_W = 20,
   parameter int WORD_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc,
   input  logic                  fetch_req,
   output logic [2*WORD_W-1:0]   instr,
   output logic                  instr_valid,
   input  logic                  ld_start,
   input  logic [ADDR_W-1:0]     ld_base,
   input  logic [ADDR_W-1:0]     ld_len,
   input  logic                  ld_valid,
   input  logic [WORD_W-1:0]     ld_data,
   output logic                  ld_ready,
   output logic                  ld_done,
`ifdef IMEM_PARITY_EN
   output logic                  par_err,
`endif
   output logic                  busy
);

   localparam int BANK_W = ADDR_W - 1;
   localparam int BANK_D = 1 << BANK_W;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t              stateReg, stateNext;
   logic [ADDR_W-1:0]   addrReg, addrNext;
   logic [ADDR_W-1:0]   remReg, remNext;
   logic                doneReg, doneNext;
   logic                validReg;
   logic                swapReg;

   logic                wrEn;
   logic                wrOdd;
   logic [BANK_W-1:0]   wrIdx;
   logic                fetchAcc;
   logic                pcOdd;
   logic [BANK_W-1:0]   pcIdx;
   logic                unusedPcHi;
   logic [WORD_W-1:0]   hiWord, loWord;

   // ---------------- loader FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
         addrReg  <= '0;
         remReg   <= '0;
         doneReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         addrReg  <= addrNext;
         remReg   <= remNext;
         doneReg  <= doneNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      addrNext  = addrReg;
      remNext   = remReg;
      doneNext  = 1'b0;
      case (stateReg)
         IDLE: begin
            if (ld_start) begin
               if (ld_len != '0) begin
                  stateNext = LOAD;
                  addrNext  = ld_base;
                  remNext   = ld_len;
               end else begin
                  // Empty load completes immediately without visiting LOAD.
                  doneNext = 1'b1;
               end
            end
         end
         LOAD: begin
            if (ld_valid) begin
               addrNext = addrReg + ADDR_W'(1);   // wraps modulo 2^ADDR_W
               remNext  = remReg - ADDR_W'(1);
               if (remReg == ADDR_W'(1)) begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign busy     = (stateReg == LOAD);
   assign ld_ready = (stateReg == LOAD);
   assign ld_done  = doneReg;

   // A write coinciding with reset is dropped so that reset cleanly aborts.
   assign wrEn  = (stateReg == LOAD) && ld_valid && !rst;
   assign wrOdd = addrReg[0];
   assign wrIdx = addrReg[ADDR_W-1:1];

   // ---------------- fetch path ----------------
   assign fetchAcc   = fetch_req && (stateReg == IDLE);
   assign pcOdd      = pc[0];
   assign pcIdx      = pc[ADDR_W-1:1];
   assign unusedPcHi = ^pc[31:ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         validReg <= 1'b0;
         swapReg  <= 1'b0;
      end else begin
         validReg <= fetchAcc;
         if (fetchAcc) begin
            swapReg <= pcOdd;
         end
      end
   end

   // Bank 0 holds even addresses, bank 1 odd addresses. For an odd pc the
   // second word is the next even address, i.e. bank-0 row pcIdx+1; that row
   // index wraps naturally, which covers the pc = 2^ADDR_W-1 case.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : bankGen
         logic [WORD_W-1:0] mem [BANK_D];
         logic [WORD_W-1:0] rdQ;
         logic [BANK_W-1:0] rdIdx;
         logic              bankWe;

         assign bankWe = wrEn && (wrOdd == (gi != 0));

         if (gi == 0) begin : evenIdx
            assign rdIdx = pcIdx + BANK_W'(pcOdd);
         end else begin : oddIdx
            assign rdIdx = pcIdx;
         end

         always_ff @(posedge clk) begin
            if (bankWe) begin
               mem[wrIdx] <= ld_data;
            end
         end

         // Read register only updates on an accepted fetch so instr holds.
         always_ff @(posedge clk) begin
            if (rst) begin
               rdQ <= '0;
            end else if (fetchAcc) begin
               rdQ <= mem[rdIdx];
            end
         end

`ifdef IMEM_PARITY_EN
         logic par [BANK_D];
         logic parQ;

         always_ff @(posedge clk) begin
            if (bankWe) begin
               par[wrIdx] <= ^ld_data;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               parQ <= 1'b0;
            end else if (fetchAcc) begin
               parQ <= par[rdIdx];
            end
         end
`endif
      end
   endgenerate

   assign hiWord      = swapReg ? bankGen[1].rdQ : bankGen[0].rdQ;
   assign loWord      = swapReg ? bankGen[0].rdQ : bankGen[1].rdQ;
   assign instr       = {hiWord, loWord};
   assign instr_valid = validReg;

`ifdef IMEM_PARITY_EN
   logic hiPar, loPar;
   assign hiPar   = swapReg ? bankGen[1].parQ : bankGen[0].parQ;
   assign loPar   = swapReg ? bankGen[0].parQ : bankGen[1].parQ;
   assign par_err = validReg && ((^{hiWord, hiPar}) || (^{loWord, loPar}));
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed scenarios plus randomized loads and
// fetches, checked against an associative-array model of memory contents.
module tb_instr_mem_loader;

   localparam int ADDR_W = 20;
   localparam int WORD_W = 16;
   localparam int MASK   = (1 << ADDR_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [31:0]         pc = '0;
   logic                fetch_req = 1'b0;
   logic [2*WORD_W-1:0] instr;
   logic                instr_valid;
   logic                ld_start = 1'b0;
   logic [ADDR_W-1:0]   ld_base = '0;
   logic [ADDR_W-1:0]   ld_len = '0;
   logic                ld_valid = 1'b0;
   logic [WORD_W-1:0]   ld_data = '0;
   logic                ld_ready;
   logic                ld_done;
   logic                busy;
`ifdef IMEM_PARITY_EN
   logic                par_err;
`endif

   int checks = 0;
   int failures = 0;

   logic [WORD_W-1:0]   model [int];      // address -> last written word
   logic [WORD_W-1:0]   ldWords [$];      // optional fixed data for next load
   logic [2*WORD_W-1:0] lastInstr = '0;   // expected held value of instr

   instr_mem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
      .instr(instr), .instr_valid(instr_valid),
      .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_done(ld_done),
`ifdef IMEM_PARITY_EN
      .par_err(par_err),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*WORD_W-1:0] expFetch(input int a);
      return {model[a & MASK], model[(a + 1) & MASK]};
   endfunction

   task automatic startLoad(input int base, input int len);
      ld_start = 1'b1;
      ld_base  = ADDR_W'(base);
      ld_len   = ADDR_W'(len);
      step();
      ld_start = 1'b0;
      $display("load start base=%05h len=%0d", base, len);
   endtask

   // Data phase of a load already in LOAD; gapMax = max idle cycles per word.
   task automatic feed(input int base, input int len, input int gapMax);
      check("busy_at_load", busy, 1);
      for (int i = 0; i < len; i++) begin
         int gaps = (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
         for (int g = 0; g < gaps; g++) begin
            ld_valid = 1'b0;
            step();
            check("busy_in_gap", busy, 1);
         end
         ld_valid = 1'b1;
         ld_data  = (i < ldWords.size()) ? ldWords[i] : WORD_W'($urandom);
         check("ready_before_hs", ld_ready, 1);
         check("no_early_done", ld_done, 0);
         step();
         ld_valid = 1'b0;
         model[(base + i) & MASK] = ld_data;
         $display("load word addr=%05h data=%04h", (base + i) & MASK, ld_data);
      end
      ldWords.delete();
      check("busy_after_last", busy, 0);
      check("ready_after_last", ld_ready, 0);
      check("done_pulse", ld_done, 1);
      step();
      check("done_one_cycle", ld_done, 0);
   endtask

   task automatic fetch(input int a);
      logic [2*WORD_W-1:0] e;
      e = expFetch(a);
      fetch_req = 1'b1;
      pc = {$urandom} & ~MASK | (a & MASK);   // upper bits are don't-care
      step();
      fetch_req = 1'b0;
      $display("fetch pc=%08h instr=%08h valid=%0b", pc, instr, instr_valid);
      check("fetch_valid", instr_valid, 1);
      check("fetch_instr", instr, e);
`ifdef IMEM_PARITY_EN
      check("fetch_par_ok", par_err, 0);
`endif
      lastInstr = e;
      step();
      check("valid_drops", instr_valid, 0);
      check("instr_holds", instr, lastInstr);
   endtask

   initial begin
      // ---- reset ----
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("rst_instr", instr, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_ready", ld_ready, 0);
      check("rst_done", ld_done, 0);
      check("rst_busy", busy, 0);
      $display("reset released");

      // ---- back-to-back load of three words, then fetch ----
      ldWords = '{16'h1111, 16'h2222, 16'h3333};
      startLoad('h10, 3);
      feed('h10, 3, 0);
      fetch('h10);
      check("fetch_0x10_literal", lastInstr, 32'h11112222);
      fetch('h11);   // odd pc: crosses banks

      // ---- load with ld_valid gaps (valid on cycles 1,4,5) ----
      startLoad('h200, 3);
      check("gap_busy", busy, 1);
      ld_valid = 1'b1; ld_data = 16'h0A01; step(); model['h200] = 16'h0A01;
      ld_valid = 1'b0; step(); check("gap_busy2", busy, 1);
      step(); check("gap_busy3", busy, 1);
      ld_valid = 1'b1; ld_data = 16'h0A02; step(); model['h201] = 16'h0A02;
      check("gap_busy4", busy, 1);
      ld_data = 16'h0A03; step(); model['h202] = 16'h0A03;
      ld_valid = 1'b0;
      check("gap_busy_end", busy, 0);
      check("gap_done", ld_done, 1);
      step();
      fetch('h200);
      fetch('h201);
      check("gap_third_word", lastInstr[WORD_W-1:0], 16'h0A03);

      // ---- wrap at top of memory ----
      ldWords = '{16'hAAAA, 16'hBBBB};
      startLoad('hFFFFF, 2);
      feed('hFFFFF, 2, 1);
      fetch('hFFFFF);
      check("wrap_literal", lastInstr, 32'hAAAABBBB);
      ldWords = '{16'hCCCC};
      startLoad('h0, 1);
      feed('h0, 1, 0);
      fetch('hFFFFF);
      check("wrap_to_zero", lastInstr, 32'hAAAACCCC);

      // ---- fetch dropped during LOAD, ld_start ignored in LOAD ----
      startLoad('h300, 2);
      fetch_req = 1'b1; pc = 32'h10;
      ld_start = 1'b1; ld_base = 20'h7; ld_len = 20'h9;
      step();
      fetch_req = 1'b0; ld_start = 1'b0;
      check("load_fetch_dropped", instr_valid, 0);
      check("load_instr_holds", instr, lastInstr);
      feed('h300, 2, 0);   // completes after exactly 2 words at 0x300
      fetch('h300);

      // ---- zero-length load ----
      startLoad('h400, 0);
      check("len0_done", ld_done, 1);
      check("len0_busy", busy, 0);
      step();
      check("len0_done_clear", ld_done, 0);
      check("len0_busy_still", busy, 0);

      // ---- fetch and ld_start in the same IDLE cycle ----
      begin
         logic [2*WORD_W-1:0] e;
         e = expFetch('h300);
         fetch_req = 1'b1; pc = 32'h300;
         ld_start = 1'b1; ld_base = 20'h300; ld_len = 20'h2;
         step();
         fetch_req = 1'b0; ld_start = 1'b0;
         check("both_fetch_valid", instr_valid, 1);
         check("both_fetch_old", instr, e);
         lastInstr = e;
         feed('h300, 2, 1);
         fetch('h300);
      end

      // ---- reset during LOAD after one of three words ----
      startLoad('h11, 3);
      ld_valid = 1'b1; ld_data = 16'h5A5A; step(); model['h11] = 16'h5A5A;
      ld_valid = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      lastInstr = '0;
      check("abort_busy", busy, 0);
      check("abort_done", ld_done, 0);
      check("abort_instr", instr, 0);
      step();
      check("abort_no_done", ld_done, 0);
      fetch('h11);
      check("abort_word_kept", lastInstr, 32'h5A5A3333);

      // ---- randomized loads and fetches ----
      for (int t = 0; t < 20; t++) begin
         int base = int'($urandom) & MASK;
         int len  = int'($urandom_range(6, 2));
         startLoad(base, len);
         feed(base, len, 2);
         for (int f = 0; f < 2; f++) begin
            fetch((base + int'($urandom_range(len - 2, 0))) & MASK);
         end
      end

`ifdef IMEM_PARITY_EN
      // ---- corrupted parity bit of word 0x10 ----
      ldWords = '{16'h1111, 16'h2222};
      startLoad('h10, 2);
      feed('h10, 2, 0);
      dut.bankGen[0].par[8] = ~dut.bankGen[0].par[8];
      fetch_req = 1'b1; pc = 32'h10;
      step();
      fetch_req = 1'b0;
      $display("parity fetch pc=%08h instr=%08h par_err=%0b", pc, instr, par_err);
      check("par_valid", instr_valid, 1);
      check("par_err", par_err, 1);
      step();
      check("par_err_clear", par_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: word-address width; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter WORD_W, default 16: memory word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc  input  32  fetch address; only pc[ADDR_W-1:0] used, upper bits ignored.
REQ-006 SHALL have port fetch_req  input  1  fetch request, sampled each cycle.
REQ-007 SHALL have port instr  output  2*WORD_W  fetched instruction {mem[a], mem[a+1]}, registered.
REQ-008 SHALL have port instr_valid  output  1  one-cycle qualifier for instr.
REQ-009 SHALL have port ld_start  input  1  begin a streaming program load.
REQ-010 SHALL have port ld_base  input  ADDR_W  first load address, latched on accepted ld_start.
REQ-011 SHALL have port ld_len  input  ADDR_W  number of words to load, latched on accepted ld_start.
REQ-012 SHALL have port ld_valid  input  1  ld_data valid.
REQ-013 SHALL have port ld_data  input  WORD_W  load word.
REQ-014 SHALL have port ld_ready  output  1  loader accepts a word this cycle.
REQ-015 SHALL have port ld_done  output  1  one-cycle pulse at load completion.
REQ-016 SHALL have port busy  output  1  high while in LOAD state.

Function
REQ-017 SHALL implement FSM states IDLE and LOAD; busy=1 and ld_ready=1 exactly in LOAD.
REQ-018 IDLE: ld_start with ld_len!=0 SHALL latch base/len and enter LOAD next cycle; ld_len==0 SHALL stay IDLE and pulse ld_done next cycle.
REQ-019 LOAD: each cycle with ld_valid&ld_ready SHALL write ld_data to mem[addr], increment addr modulo 2^ADDR_W, decrement remaining count.
REQ-020 Handshake on the last word (remaining==1) SHALL return to IDLE and pulse ld_done in the following cycle; ld_valid low SHALL stall with no state change.
REQ-021 ld_start in LOAD SHALL be ignored.
REQ-022 fetch_req in IDLE SHALL produce instr={mem[pc], mem[(pc+1) mod 2^ADDR_W]} with instr_valid=1 one cycle later (latency 1); the word at pc occupies the upper half.
REQ-023 fetch_req in LOAD SHALL be dropped: instr_valid=0, instr holds previous value.
REQ-024 Without fetch_req, instr_valid SHALL be 0 and instr SHALL hold.
REQ-025 fetch_req and ld_start in the same IDLE cycle SHALL both be serviced: fetch reads pre-load contents, load begins.
REQ-026 Fetch at pc=2^ADDR_W-1 SHALL wrap the second word to address 0.

Reset
REQ-027 rst SHALL force IDLE, instr=0, instr_valid=0, ld_ready=0, ld_done=0, busy=0 (and par_err=0 when compiled in) at the next rising edge.
REQ-028 rst during LOAD SHALL abort the load; already-written words SHALL remain; no ld_done pulse.
REQ-029 Memory array SHALL NOT be reset; unwritten contents are undefined.

Configuration
REQ-030 With macro IMEM_PARITY_EN defined, SHALL store one even-parity bit per word on load and add output par_err (1 bit), asserted with instr_valid when either fetched word fails parity, reset 0.
REQ-031 Without IMEM_PARITY_EN, no parity storage and no par_err port SHALL exist; behaviour otherwise identical.

Verification
REQ-032 Reset, ld_start base=0x10 len=3, data 0x1111,0x2222,0x3333 back-to-back -> ld_ready 3 cycles, ld_done pulse next cycle; fetch pc=0x10 -> instr=0x11112222 after 1 cycle.
REQ-033 Load with ld_valid gaps (valid on cycles 1,4,5) len=3 -> exactly 3 writes, busy held until last handshake.
REQ-034 Load base=0xFFFFF len=2 data 0xAAAA,0xBBBB; fetch pc=0xFFFFF -> instr=0xAAAABBBB (wrap).
REQ-035 fetch_req during LOAD -> instr_valid stays 0; ld_len=0 -> ld_done pulse, busy never high.
REQ-036 rst asserted after 1 of 3 words -> IDLE, no ld_done; fetch that address returns written word.
REQ-037 With IMEM_PARITY_EN, force-flip stored parity bit of word 0x10 -> fetch pc=0x10 gives par_err=1 with instr_valid.
